// File: rtl/uart_pkg.sv
// Shared UART definitions: the system clock divider and the receive timeout FSM states.
package uart_pkg;

    // System clocks per UART bit period; must track the baud generator configuration.
    localparam int UART_CLK_DIV = 16;

    typedef enum logic [1:0] {
        T_EMPTY,
        T_COUNT,
        T_FIRED
    } uart_tmo_state_t;

endpackage

// File: rtl/uart_fifo_core.sv
// First-word-fall-through FIFO with extra-MSB pointers; shared by the RX and TX paths.
module uart_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic             push_ok,
    output logic             pop_ok
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Handshake: push is accepted when not full, or when full but a pop frees the slot
    // in the same cycle; pop is accepted only when not empty. Flush overrides both.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each completed byte into a FIFO and raises
// 16550-style overrun, character-timeout and threshold interrupts.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 40 * UART_CLK_DIV,
    localparam int AW = $clog2(DEPTH),
    localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx_ready,
    input  logic [7:0]      rx_data,
    input  logic            pop,
    input  logic            flush,
    input  logic            clr_overrun,
    input  logic [AW:0]     thresh,
    output logic [7:0]      pop_data,
    output logic            empty,
    output logic            full,
    output logic [AW:0]     level,
    output logic            overrun,
    output logic            timeout,
    output logic            irq,
    output uart_tmo_state_t tmo_state
);

    logic          rdy_q;
    logic          push;
    logic          push_ok;
    logic          pop_ok;
    logic          act;
    logic [AW:0]   level_nxt;
    logic [TW-1:0] tcnt;

    // rdy_q resets high so a level already present at reset release is not taken as a new byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rdy_q <= 1'b1;
        else       rdy_q <= rx_ready;
    end

    assign push = rx_ready & ~rdy_q;

    uart_fifo_core #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok)
    );

    assign level_nxt = level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    assign act       = push | pop_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                       overrun <= 1'b0;
        else if (push && full && !pop_ok && !flush)      overrun <= 1'b1;
        else if (clr_overrun)                            overrun <= 1'b0;
    end

    // Any receive or read activity, including a byte dropped on overrun, restarts the idle count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_state <= T_EMPTY;
            tcnt      <= '0;
            timeout   <= 1'b0;
        end else if (flush) begin
            tmo_state <= T_EMPTY;
            tcnt      <= '0;
            timeout   <= 1'b0;
        end else begin
            case (tmo_state)
                T_EMPTY: begin
                    tcnt <= '0;
                    if (level_nxt != '0) tmo_state <= T_COUNT;
                end
                T_COUNT: begin
                    if (act) begin
                        tcnt <= '0;
                        if (level_nxt == '0) tmo_state <= T_EMPTY;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_state <= T_FIRED;
                        timeout   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                T_FIRED: begin
                    if (act) begin
                        tcnt      <= '0;
                        timeout   <= 1'b0;
                        tmo_state <= (level_nxt == '0) ? T_EMPTY : T_COUNT;
                    end
                end
                default: begin
                    tmo_state <= T_EMPTY;
                    tcnt      <= '0;
                    timeout   <= 1'b0;
                end
            endcase
        end
    end

    assign irq = ((thresh != '0) && (level >= thresh)) | timeout | overrun;

endmodule
